// File: rtl/pack_send_frame.sv
// Packet-to-byte framer: serialises fixed-size packets LSB-byte-first into a byte FIFO,
// inserting FF FF FF 7F sync markers and dropping whole packets when space runs out.
module pack_send_frame #(
    parameter int PKT_BYTES     = 16,
    parameter int DEPTH_LOG2    = 8,
    parameter int SYNC_INTERVAL = 64,
    parameter int OVF_STRETCH   = 2048
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sync_in,
    input  logic                   pkt_valid,
    input  logic [8*PKT_BYTES-1:0] pkt_data,
    output logic                   pkt_ready,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow,
    output logic [15:0]            drop_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int IDX_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam int CNT_W = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL) : 1;
    localparam int STR_W = (OVF_STRETCH > 0) ? $clog2(OVF_STRETCH + 1) : 1;

    localparam int PKT_LEN_I      = PKT_BYTES;
    localparam int PKT_SYNC_LEN_I = PKT_BYTES + 4;
    localparam int LAST_IDX_I     = PKT_BYTES - 1;
    localparam int SYNC_LAST_I    = SYNC_INTERVAL - 1;
    localparam int STRETCH_I      = OVF_STRETCH;

    localparam logic [DEPTH_LOG2:0] FIFO_SIZE    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] PKT_LEN      = PKT_LEN_I[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] PKT_SYNC_LEN = PKT_SYNC_LEN_I[DEPTH_LOG2:0];
    localparam logic [IDX_W-1:0]    LAST_IDX     = LAST_IDX_I[IDX_W-1:0];
    localparam logic [CNT_W-1:0]    SYNC_LAST    = SYNC_LAST_I[CNT_W-1:0];
    localparam logic [STR_W-1:0]    STRETCH_LOAD = STRETCH_I[STR_W-1:0];

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA
    } state_t;

    state_t                 state;
    logic [8*PKT_BYTES-1:0] latched;
    logic [IDX_W-1:0]       byteIdx;
    logic [1:0]             syncIdx;
    logic                   syncPending;
    logic [CNT_W-1:0]       pktCnt;
    logic [STR_W-1:0]       stretchCnt;
    logic [STR_W-1:0]       stretchNext;

    logic [7:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wrPtr;
    logic [DEPTH_LOG2-1:0]  rdPtr;
    logic [DEPTH_LOG2:0]    count;

    logic                   accept;
    logic                   needSync;
    logic                   fits;
    logic                   dropEv;
    logic                   wrEn;
    logic                   rdEn;
    logic [DEPTH_LOG2:0]    required;
    logic [DEPTH_LOG2:0]    freeSpace;
    logic [7:0]             wrData;

    // Reset is gated in so the port reads 0 while rst is held, not just after it.
    assign pkt_ready = (state == IDLE) && sync_in && !rst;
    assign accept    = pkt_valid && pkt_ready;
    assign needSync  = syncPending || (pktCnt == SYNC_LAST);
    assign required  = needSync ? PKT_SYNC_LEN : PKT_LEN;
    // Registered occupancy only: a pop in this same cycle is deliberately not credited.
    assign freeSpace = FIFO_SIZE - count;
    assign fits      = (freeSpace >= required);
    assign dropEv    = accept && !fits;
    assign wrEn      = (state != IDLE);
    assign rdEn      = (!out_valid || out_ready) && (count != '0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wrData = latched[{byteIdx, 3'b000} +: 8];
        if (state == SYNC) begin
            wrData = (syncIdx == 2'd3) ? 8'h7F : 8'hFF;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            latched     <= '0;
            byteIdx     <= '0;
            syncIdx     <= '0;
            syncPending <= 1'b1;
            pktCnt      <= '0;
            drop_count  <= '0;
        end else begin
            if (!sync_in) begin
                syncPending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (fits) begin
                            latched <= pkt_data;
                            byteIdx <= '0;
                            if (needSync) begin
                                state       <= SYNC;
                                syncIdx     <= '0;
                                syncPending <= 1'b0;
                                pktCnt      <= '0;
                            end else begin
                                state  <= DATA;
                                pktCnt <= pktCnt + 1'b1;
                            end
                        end else begin
                            // Whole packet is swallowed; the stream must resync afterwards.
                            syncPending <= 1'b1;
                            if (drop_count != 16'hFFFF) begin
                                drop_count <= drop_count + 1'b1;
                            end
                        end
                    end
                end
                SYNC: begin
                    syncIdx <= syncIdx + 1'b1;
                    if (syncIdx == 2'd3) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    byteIdx <= byteIdx + 1'b1;
                    if (byteIdx == LAST_IDX) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stretchNext = stretchCnt;
        if (dropEv) begin
            stretchNext = STRETCH_LOAD;
        end else if (stretchCnt != '0) begin
            stretchNext = stretchCnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stretchCnt <= '0;
            overflow   <= 1'b0;
        end else begin
            stretchCnt <= stretchNext;
            overflow   <= (stretchNext != '0);
        end
    end

    // NOTE: the byte store has no reset; count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (rdEn) begin
                out_data  <= mem[rdPtr];
                out_valid <= 1'b1;
                rdPtr     <= rdPtr + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            case ({wrEn, rdEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
